qb_measure_expect: RTL and testbench

- Downstream consumer of the 1-qubit variational circuit output `psi_f`.
- Takes the final 1-qubit state vector: 4 signed fixed-point words, stored as re0, im0, re1, im1.
- Computes the basis probabilities p0 = |a0|^2 and p1 = |a1|^2, and the Pauli-Z expectation <Z> = p0 - p1.
- Uses a single time-shared squarer over 4 cycles, with valid/ready handshakes on both sides. Feeds the host/optimiser readout path.

---
 rtl/qb_measure_expect_pkg.sv | 36 +++
 rtl/qb_measure_expect_if.sv | 48 ++++
 rtl/qb_measure_expect_square.sv | 11 +
 rtl/qb_measure_expect.sv | 148 ++++++++++++++
 tb/tb_qb_measure_expect.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/qb_measure_expect_pkg.sv
// Shared types, constants and the saturation helper for the measurement block.
package qvc_pkg;

    localparam int N        = 16;
    localparam int FRAC     = 14;
    localparam int NORM_TOL = 64;
    localparam int ONE      = 1 << FRAC;

    typedef logic signed [N-1:0]   fxp_t;
    typedef logic signed [2*N-1:0] sq_t;
    typedef logic signed [2*N:0]   acc_t;

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        FIN,
        OUT
    } meas_state_t;

    localparam acc_t SAT_HI = acc_t'((1 << (N-1)) - 1);
    localparam acc_t SAT_LO = acc_t'(-(1 << (N-1)));

    // Clamp an already-shifted accumulator value into the signed word range.
    function automatic fxp_t sat_fxp(input acc_t a);
        fxp_t r;
        if (a > SAT_HI) begin
            r = fxp_t'(SAT_HI);
        end else if (a < SAT_LO) begin
            r = fxp_t'(SAT_LO);
        end else begin
            r = fxp_t'(a);
        end
        return r;
    endfunction

endpackage

// File: rtl/qb_measure_expect_if.sv
// Handshake bundle for the measurement block: vector input side and result
// output side. norm_err exists only when MEAS_NORM_CHECK_EN is defined.
interface qb_measure_expect_if;
    import qvc_pkg::*;

    logic in_valid;
    logic in_ready;
    fxp_t psi_in [0:3];
    logic out_valid;
    logic out_ready;
    fxp_t prob0;
    fxp_t prob1;
    fxp_t expect_z;
`ifdef MEAS_NORM_CHECK_EN
    logic norm_err;
`endif

    // Producer of vectors and consumer of results (host side).
    modport master (
        output in_valid,
        output psi_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  prob0,
        input  prob1,
`ifdef MEAS_NORM_CHECK_EN
        input  norm_err,
`endif
        input  expect_z
    );

    // The measurement block itself.
    modport slave (
        input  in_valid,
        input  psi_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output prob0,
        output prob1,
`ifdef MEAS_NORM_CHECK_EN
        output norm_err,
`endif
        output expect_z
    );

endinterface

// File: rtl/qb_measure_expect_square.sv
// Combinational signed squarer, full 2N-bit product.
module fxp_square
    import qvc_pkg::*;
(
    input  fxp_t a_i,
    output sq_t  sq_o
);

    assign sq_o = sq_t'(a_i) * sq_t'(a_i);

endmodule

// File: rtl/qb_measure_expect.sv
// qb_measure_expect: basis probabilities and <Z> of a 1-qubit state vector
// using one time-shared squarer over four cycles.
// Optional macro MEAS_NORM_CHECK_EN adds the norm_err output.
module qb_measure_expect
    import qvc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    qb_measure_expect_if.slave      bus
);

    meas_state_t state_q, state_d;
    fxp_t        psi_q [0:3];
    fxp_t        psi_d [0:3];
    logic [1:0]  idx_q, idx_d;
    acc_t        acc0_q, acc0_d;
    acc_t        acc1_q, acc1_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    fxp_t        prob0_q, prob0_d;
    fxp_t        prob1_q, prob1_d;
    fxp_t        expz_q, expz_d;
`ifdef MEAS_NORM_CHECK_EN
    typedef logic signed [2*N+1:0] wide_t;
    logic        norm_err_q, norm_err_d;
    wide_t       normSum, normDev, normAbs;
`endif

    sq_t         sqVal;
    logic        accept;
    logic        outFire;

    assign accept  = (state_q == IDLE) && bus.in_valid && in_ready_q;
    assign outFire = (state_q == OUT) && out_valid_q && bus.out_ready;

    fxp_square uSquare (
        .a_i  (psi_q[idx_q]),
        .sq_o (sqVal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)        state_d = SQ;
            SQ:   if (idx_q == 2'd3) state_d = FIN;
            FIN:                     state_d = OUT;
            OUT:  if (outFire)       state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        psi_d       = psi_q;
        idx_d       = idx_q;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        prob0_d     = prob0_q;
        prob1_d     = prob1_q;
        expz_d      = expz_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
`ifdef MEAS_NORM_CHECK_EN
        norm_err_d  = norm_err_q;
        normSum     = wide_t'(acc0_q) + wide_t'(acc1_q);
        normDev     = (normSum >>> FRAC) - wide_t'(ONE);
        normAbs     = (normDev < 0) ? -normDev : normDev;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    psi_d  = bus.psi_in;
                    acc0_d = '0;
                    acc1_d = '0;
                    idx_d  = 2'd0;
                end
            end
            SQ: begin
                if (idx_q[1] == 1'b0) begin
                    acc0_d = acc0_q + acc_t'(sqVal);
                end else begin
                    acc1_d = acc1_q + acc_t'(sqVal);
                end
                idx_d = idx_q + 2'd1;
            end
            FIN: begin
                prob0_d = sat_fxp(acc0_q >>> FRAC);
                prob1_d = sat_fxp(acc1_q >>> FRAC);
                expz_d  = sat_fxp((acc0_q - acc1_q) >>> FRAC);
`ifdef MEAS_NORM_CHECK_EN
                norm_err_d = (normAbs > wide_t'(NORM_TOL));
`endif
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) psi_q[i] <= '0;
            idx_q       <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            prob0_q     <= '0;
            prob1_q     <= '0;
            expz_q      <= '0;
`ifdef MEAS_NORM_CHECK_EN
            norm_err_q  <= 1'b0;
`endif
        end else begin
            psi_q       <= psi_d;
            idx_q       <= idx_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            prob0_q     <= prob0_d;
            prob1_q     <= prob1_d;
            expz_q      <= expz_d;
`ifdef MEAS_NORM_CHECK_EN
            norm_err_q  <= norm_err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.prob0     = prob0_q;
    assign bus.prob1     = prob1_q;
    assign bus.expect_z  = expz_q;
`ifdef MEAS_NORM_CHECK_EN
    assign bus.norm_err  = norm_err_q;
`endif

endmodule

// File: tb/tb_qb_measure_expect.sv
// Self-checking bench for qb_measure_expect: vector table plus hand-written
// backpressure and mid-transaction reset sequences.
module tb_qb_measure_expect;
    import qvc_pkg::*;

    typedef struct {
        string        name;
        logic [15:0]  psi [0:3];
        logic [15:0]  prob0;
        logic [15:0]  prob1;
        logic [15:0]  ez;
        logic         nerr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    vec_t vecs [0:8];

    qb_measure_expect_if bus ();

    qb_measure_expect dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResults(input string tag, input vec_t v);
        checkOutput({tag, " prob0"}, bus.prob0, v.prob0);
        checkOutput({tag, " prob1"}, bus.prob1, v.prob1);
        checkOutput({tag, " expect_z"}, bus.expect_z, v.ez);
`ifdef MEAS_NORM_CHECK_EN
        checkOutput({tag, " norm_err"}, 16'(bus.norm_err), 16'(v.nerr));
`endif
    endtask

    // Wait for the result after an accept edge; called at the negedge just
    // after the accepting posedge, returns with out_valid visible.
    task automatic waitResult(input string tag);
        int cycles;
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " latency"}, 16'(cycles), 16'd5);
    endtask

    // Full transaction: present, accept, wait, check, handshake out.
    task automatic applyStimulus(input vec_t v);
        int cycles;
        cycles = 0;
        while (!bus.in_ready && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({v.name, " in_ready"}, 16'(bus.in_ready), 16'd1);
        for (int i = 0; i < 4; i++) bus.psi_in[i] = v.psi[i];
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) bus.psi_in[i] = 16'h1234;
        waitResult(v.name);
        checkResults(v.name, v);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({v.name, " out_valid_drop"}, 16'(bus.out_valid), 16'd0);
        checkOutput({v.name, " in_ready_back"}, 16'(bus.in_ready), 16'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        vecs[0] = '{"ket0",    '{16'h4000, 16'h0000, 16'h0000, 16'h0000}, 16'h4000, 16'h0000, 16'h4000, 1'b0};
        vecs[1] = '{"plus",    '{16'h2D41, 16'h0000, 16'h2D41, 16'h0000}, 16'h1FFF, 16'h1FFF, 16'h0000, 1'b0};
        vecs[2] = '{"i_ket1",  '{16'h0000, 16'h0000, 16'h0000, 16'h4000}, 16'h0000, 16'h4000, 16'hC000, 1'b0};
        vecs[3] = '{"neg_ket0",'{16'hC000, 16'h0000, 16'h0000, 16'h0000}, 16'h4000, 16'h0000, 16'h4000, 1'b0};
        vecs[4] = '{"floor_z", '{16'h0000, 16'h0000, 16'h2D41, 16'h0000}, 16'h0000, 16'h1FFF, 16'hE000, 1'b1};
        vecs[5] = '{"mixed",   '{16'h2000, 16'h2000, 16'h2000, 16'h0000}, 16'h2000, 16'h1000, 16'h1000, 1'b1};
        vecs[6] = '{"min_re0", '{16'h8000, 16'h0000, 16'h0000, 16'h0000}, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1};
        vecs[7] = '{"neg_clip",'{16'h0000, 16'h0000, 16'h8000, 16'h8000}, 16'h0000, 16'h7FFF, 16'h8000, 1'b1};
        vecs[8] = '{"sat_all", '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1};

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus.psi_in[i] = '0;
        #2 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst in_ready", 16'(bus.in_ready), 16'd0);
        checkOutput("rst out_valid", 16'(bus.out_valid), 16'd0);
        checkOutput("rst prob0", bus.prob0, 16'h0000);
        checkOutput("rst prob1", bus.prob1, 16'h0000);
        checkOutput("rst expect_z", bus.expect_z, 16'h0000);
`ifdef MEAS_NORM_CHECK_EN
        checkOutput("rst norm_err", 16'(bus.norm_err), 16'd0);
`endif
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        checkOutput("in_ready before edge", 16'(bus.in_ready), 16'd0);
        @(negedge clk);
        checkOutput("in_ready after edge", 16'(bus.in_ready), 16'd1);
        checkOutput("early out_ready no effect", 16'(bus.out_valid), 16'd0);
        bus.out_ready = 1'b0;

        // Table-driven vectors
        for (int t = 0; t < 9; t++) applyStimulus(vecs[t]);

        // Reset two edges into SQ: outputs clear at once, no result appears
        for (int i = 0; i < 4; i++) bus.psi_in[i] = vecs[1].psi[i];
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst prob0", bus.prob0, 16'h0000);
        checkOutput("midrst prob1", bus.prob1, 16'h0000);
        checkOutput("midrst in_ready", 16'(bus.in_ready), 16'd0);
        for (int c = 0; c < 2; c++) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("midrst no out_valid", 16'(bus.out_valid), 16'd0);
        end
        applyStimulus(vecs[0]);

        // Backpressure: hold results while a second vector waits upstream
        for (int i = 0; i < 4; i++) bus.psi_in[i] = vecs[1].psi[i];
        bus.in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) bus.psi_in[i] = vecs[2].psi[i];
        waitResult("bp first");
        checkResults("bp first", vecs[1]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bp hold out_valid", 16'(bus.out_valid), 16'd1);
            checkOutput("bp hold in_ready", 16'(bus.in_ready), 16'd0);
            checkOutput("bp hold prob0", bus.prob0, vecs[1].prob0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("bp release out_valid", 16'(bus.out_valid), 16'd0);
        checkOutput("bp release in_ready", 16'(bus.in_ready), 16'd1);
        checkOutput("bp kept prob0", bus.prob0, vecs[1].prob0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("bp second accepted", 16'(bus.in_ready), 16'd0);
        waitResult("bp second");
        checkResults("bp second", vecs[2]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("bp second done", 16'(bus.out_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
